tbu_lifo: RTL and testbench

Output reordering stage placed directly downstream of the traceback unit in the Viterbi decoder. Traceback emits decoded bits (`d_o` qualified by `wr_en`) newest-first, so this block captures each traceback block into one of two ping-pong LIFO banks. It then replays that block oldest-first to the decoder output over a valid/ready handshake while the other bank fills. A sticky flag reports bits dropped because both banks were occupied.

---
 rtl/tbu_lifo.sv | 159 +++++++++++++++
 tb/tb_tbu_lifo.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tbu_lifo.sv
// Ping-pong LIFO reorder stage behind the Viterbi traceback unit.
// Each block arrives newest-first and leaves oldest-first; blocks leave in the order they closed.
module tbu_lifo #(
  parameter int DEPTH = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  input  logic wr_en,
  input  logic flush,
  input  logic dout_ready,
  output logic d_out,
  output logic d_valid,
  output logic d_last,
  output logic overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, DRAIN} state_e;

  logic [DEPTH-1:0] mem_q [2];
  logic [1:0]       full_q, full_d;
  logic [AW:0]      len_q [2];
  logic [AW:0]      len_d [2];
  logic             wbank_q, wbank_d;
  logic [AW-1:0]    wcnt_q, wcnt_d;
  logic             overflow_q, overflow_d;

  state_e           state_q, state_d;
  logic             rbank_q, rbank_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic             d_out_q, d_out_d;
  logic             d_valid_q, d_valid_d;
  logic             d_last_q, d_last_d;

  logic             wr_ok, close_full, close_any;
  logic [AW:0]      close_len;
  logic             handshake, last_hs, nbank;
  logic [AW:0]      len_m1_cur, len_m1_nxt;
  logic [AW-1:0]    ptr_cur, ptr_nxt, ptr_dec;

  // A full write bank blocks the writer; the reader frees it only from the next cycle on.
  assign wr_ok      = wr_en && !full_q[wbank_q];
  assign close_full = wr_ok && (wcnt_q == AW'(DEPTH - 1));
  assign close_any  = close_full || (flush && (wr_ok || (wcnt_q != '0)));
  assign close_len  = {1'b0, wcnt_q} + (AW+1)'(wr_ok);

  assign handshake  = d_valid_q && dout_ready;
  assign last_hs    = handshake && (rptr_q == '0);
  assign nbank      = ~rbank_q;
  assign len_m1_cur = len_q[rbank_q] - (AW+1)'(1);
  assign len_m1_nxt = len_q[nbank] - (AW+1)'(1);
  assign ptr_cur    = len_m1_cur[AW-1:0];
  assign ptr_nxt    = len_m1_nxt[AW-1:0];
  assign ptr_dec    = rptr_q - AW'(1);

  always_comb begin
    wbank_d    = wbank_q;
    wcnt_d     = wcnt_q;
    overflow_d = overflow_q;
    len_d      = len_q;
    if (wr_en && full_q[wbank_q]) overflow_d = 1'b1;
    if (close_any) begin
      len_d[wbank_q] = close_len;
      wbank_d        = ~wbank_q;
      wcnt_d         = '0;
    end else if (wr_ok) begin
      wcnt_d = wcnt_q + AW'(1);
    end
  end

  // Reader only clears full banks and writer only closes non-full ones, so they never collide.
  always_comb begin
    full_d = full_q;
    if (last_hs)   full_d[rbank_q] = 1'b0;
    if (close_any) full_d[wbank_q] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    rbank_d   = rbank_q;
    rptr_d    = rptr_q;
    d_out_d   = d_out_q;
    d_valid_d = d_valid_q;
    d_last_d  = d_last_q;
    case (state_q)
      IDLE: begin
        if (full_q[rbank_q]) begin
          state_d   = DRAIN;
          rptr_d    = ptr_cur;
          d_out_d   = mem_q[rbank_q][ptr_cur];
          d_valid_d = 1'b1;
          d_last_d  = (ptr_cur == '0);
        end
      end
      DRAIN: begin
        if (handshake) begin
          if (rptr_q != '0) begin
            rptr_d   = ptr_dec;
            d_out_d  = mem_q[rbank_q][ptr_dec];
            d_last_d = (ptr_dec == '0);
          end else begin
            rbank_d = nbank;
            if (full_q[nbank]) begin
              rptr_d   = ptr_nxt;
              d_out_d  = mem_q[nbank][ptr_nxt];
              d_last_d = (ptr_nxt == '0);
            end else begin
              state_d   = IDLE;
              d_valid_d = 1'b0;
              d_out_d   = 1'b0;
              d_last_d  = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wbank_q][wcnt_q] <= d_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q     <= '0;
      len_q      <= '{default: '0};
      wbank_q    <= 1'b0;
      wcnt_q     <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      rbank_q    <= 1'b0;
      rptr_q     <= '0;
      d_out_q    <= 1'b0;
      d_valid_q  <= 1'b0;
      d_last_q   <= 1'b0;
    end else begin
      full_q     <= full_d;
      len_q      <= len_d;
      wbank_q    <= wbank_d;
      wcnt_q     <= wcnt_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      rbank_q    <= rbank_d;
      rptr_q     <= rptr_d;
      d_out_q    <= d_out_d;
      d_valid_q  <= d_valid_d;
      d_last_q   <= d_last_d;
    end
  end

  assign d_out    = d_out_q;
  assign d_valid  = d_valid_q;
  assign d_last   = d_last_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_tbu_lifo.sv
// Directed bench for tbu_lifo with DEPTH = 8; inputs driven and outputs sampled on the falling edge.
module tb_tbu_lifo;

  logic clk = 1'b0;
  logic rst, d_in, wr_en, flush, dout_ready;
  logic d_out, d_valid, d_last, overflow;

  int errors = 0;
  int checks = 0;

  logic got_d [$];
  logic got_l [$];
  int   first_c, last_c;

  tbu_lifo #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .wr_en(wr_en), .flush(flush),
    .dout_ready(dout_ready), .d_out(d_out), .d_valid(d_valid),
    .d_last(d_last), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; flush = 1'b0; d_in = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Gathers every handshaked bit for ncyc cycles with dout_ready held high.
  task automatic collect(input int ncyc);
    got_d.delete(); got_l.delete();
    first_c = -1; last_c = -1;
    dout_ready = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      if (d_valid) begin
        got_d.push_back(d_out);
        got_l.push_back(d_last);
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; flush = 1'b0; d_in = 1'b0; dout_ready = 1'b0;
    tick(); tick();
    checks++; if (d_out !== 1'b0)    begin errors++; $display("FAIL reset_d_out: got %b expected 0", d_out); end
    checks++; if (d_valid !== 1'b0)  begin errors++; $display("FAIL reset_d_valid: got %b expected 0", d_valid); end
    checks++; if (d_last !== 1'b0)   begin errors++; $display("FAIL reset_d_last: got %b expected 0", d_last); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] blk;
    blk = 8'b1011_1001;
    do_reset();
    dout_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; d_in = blk[i];
      tick();
    end
    wr_en = 1'b0;
    checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL basic_latency_early: got %b expected 0", d_valid); end
    tick();
    checks++; if (d_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: got %b expected 1", d_valid); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (d_valid !== 1'b1 || d_out !== blk[7-k] || d_last !== (k == 7)) begin
        errors++;
        $display("FAIL basic_bit%0d: got v=%b d=%b l=%b expected v=1 d=%b l=%b", k, d_valid, d_out, d_last, blk[7-k], (k == 7));
      end
      tick();
    end
    checks++; if (d_valid !== 1'b0)  begin errors++; $display("FAIL basic_end_valid: got %b expected 0", d_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] blk;
    blk = 16'hC35A;
    do_reset();
    dout_ready = 1'b1;
    got_d.delete(); got_l.delete();
    first_c = -1; last_c = -1;
    for (int c = 0; c < 30; c++) begin
      wr_en = (c < 16);
      d_in  = (c < 16) ? blk[c] : 1'b0;
      tick();
      if (d_valid) begin
        got_d.push_back(d_out);
        got_l.push_back(d_last);
        if (first_c < 0) first_c = c;
        last_c = c;
      end
    end
    wr_en = 1'b0;
    checks++; if (got_d.size() != 16) begin errors++; $display("FAIL b2b_count: got %0d expected 16", got_d.size()); end
    checks++; if (first_c != 8) begin errors++; $display("FAIL b2b_first_cycle: got %0d expected 8", first_c); end
    checks++; if (last_c - first_c != 15) begin errors++; $display("FAIL b2b_gap: got span %0d expected 15", last_c - first_c); end
    for (int k = 0; k < 16 && k < got_d.size(); k++) begin
      checks++;
      if (got_d[k] !== ((k < 8) ? blk[7-k] : blk[23-k]) || got_l[k] !== (k == 7 || k == 15)) begin
        errors++;
        $display("FAIL b2b_bit%0d: got d=%b l=%b expected d=%b l=%b", k, got_d[k], got_l[k],
                 ((k < 8) ? blk[7-k] : blk[23-k]), (k == 7 || k == 15));
      end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_flush();
    logic [2:0] blk;
    blk = 3'b011;
    do_reset();
    dout_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; d_in = blk[i];
      tick();
    end
    wr_en = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    collect(12);
    checks++; if (got_d.size() != 3) begin errors++; $display("FAIL flush_count: got %0d expected 3", got_d.size()); end
    checks++; if (first_c != 1) begin errors++; $display("FAIL flush_latency: got %0d expected 1", first_c); end
    for (int k = 0; k < 3 && k < got_d.size(); k++) begin
      checks++;
      if (got_d[k] !== blk[2-k] || got_l[k] !== (k == 2)) begin
        errors++;
        $display("FAIL flush_bit%0d: got d=%b l=%b expected d=%b l=%b", k, got_d[k], got_l[k], blk[2-k], (k == 2));
      end
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    collect(10);
    checks++; if (got_d.size() != 0) begin errors++; $display("FAIL flush_empty: got %0d bits expected 0", got_d.size()); end
    wr_en = 1'b1; d_in = 1'b1;
    tick();
    d_in = 1'b0; flush = 1'b1;
    tick();
    wr_en = 1'b0; flush = 1'b0;
    collect(10);
    checks++;
    if (got_d.size() != 2 || got_d[0] !== 1'b0 || got_d[1] !== 1'b1 || got_l[0] !== 1'b0 || got_l[1] !== 1'b1) begin
      errors++;
      $display("FAIL flush_with_write: got %0d bits expected 2 bits d=0,1 l=0,1", got_d.size());
    end
  endtask

  task automatic test_overflow();
    logic [16:0] blk;
    blk = 17'h1_3C96;
    do_reset();
    dout_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; d_in = blk[i];
      tick();
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b expected 0", overflow); end
    d_in = blk[16];
    tick();
    wr_en = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (d_valid !== 1'b1 || d_out !== blk[7] || d_last !== 1'b0) begin
        errors++;
        $display("FAIL ovf_stall%0d: got v=%b d=%b l=%b expected v=1 d=%b l=0", s, d_valid, d_out, d_last, blk[7]);
      end
      tick();
    end
    collect(30);
    checks++; if (got_d.size() != 16) begin errors++; $display("FAIL ovf_count: got %0d expected 16", got_d.size()); end
    for (int k = 0; k < 16 && k < got_d.size(); k++) begin
      checks++;
      if (got_d[k] !== ((k < 8) ? blk[7-k] : blk[23-k]) || got_l[k] !== (k == 7 || k == 15)) begin
        errors++;
        $display("FAIL ovf_bit%0d: got d=%b l=%b expected d=%b l=%b", k, got_d[k], got_l[k],
                 ((k < 8) ? blk[7-k] : blk[23-k]), (k == 7 || k == 15));
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_random_ready();
    logic [15:0] blk;
    logic        prev_stall, prev_d, prev_l;
    blk = 16'h96E1;
    do_reset();
    got_d.delete(); got_l.delete();
    prev_stall = 1'b0; prev_d = 1'b0; prev_l = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (prev_stall) begin
        checks++;
        if (d_valid !== 1'b1 || d_out !== prev_d || d_last !== prev_l) begin
          errors++;
          $display("FAIL rand_stable_c%0d: got v=%b d=%b l=%b expected v=1 d=%b l=%b", c, d_valid, d_out, d_last, prev_d, prev_l);
        end
      end
      dout_ready = 1'($urandom_range(0, 1));
      wr_en = (c < 16);
      d_in  = (c < 16) ? blk[c] : 1'b0;
      if (d_valid && dout_ready) begin
        got_d.push_back(d_out);
        got_l.push_back(d_last);
      end
      prev_stall = d_valid && !dout_ready;
      prev_d = d_out;
      prev_l = d_last;
      tick();
    end
    wr_en = 1'b0;
    checks++; if (got_d.size() != 16) begin errors++; $display("FAIL rand_count: got %0d expected 16", got_d.size()); end
    for (int k = 0; k < 16 && k < got_d.size(); k++) begin
      checks++;
      if (got_d[k] !== ((k < 8) ? blk[7-k] : blk[23-k]) || got_l[k] !== (k == 7 || k == 15)) begin
        errors++;
        $display("FAIL rand_bit%0d: got d=%b l=%b expected d=%b l=%b", k, got_d[k], got_l[k],
                 ((k < 8) ? blk[7-k] : blk[23-k]), (k == 7 || k == 15));
      end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rand_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] blk_a, blk_b;
    blk_a = 8'h6B;
    blk_b = 8'hD2;
    do_reset();
    dout_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; d_in = blk_a[i];
      tick();
    end
    wr_en = 1'b0;
    tick();
    checks++; if (d_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid: got %b expected 1", d_valid); end
    dout_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; d_in = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (d_valid !== 1'b0 || d_out !== 1'b0 || d_last !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL rmid_outputs: got v=%b d=%b l=%b o=%b expected all 0", d_valid, d_out, d_last, overflow);
    end
    collect(12);
    checks++; if (got_d.size() != 0) begin errors++; $display("FAIL rmid_stale: got %0d bits expected 0", got_d.size()); end
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; d_in = blk_b[i];
      tick();
    end
    wr_en = 1'b0;
    collect(20);
    checks++; if (got_d.size() != 8) begin errors++; $display("FAIL rmid_count: got %0d expected 8", got_d.size()); end
    for (int k = 0; k < 8 && k < got_d.size(); k++) begin
      checks++;
      if (got_d[k] !== blk_b[7-k] || got_l[k] !== (k == 7)) begin
        errors++;
        $display("FAIL rmid_bit%0d: got d=%b l=%b expected d=%b l=%b", k, got_d[k], got_l[k], blk_b[7-k], (k == 7));
      end
    end
  endtask

  initial begin
    rst = 1'b1; d_in = 1'b0; wr_en = 1'b0; flush = 1'b0; dout_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_flush();
    test_overflow();
    test_random_ready();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
